// File: rtl/sample_scheduler.sv
// Sample scheduler: buffers decoder samples in a FIFO and releases one to the modulator every
// CLKS_PER_SAMPLE clocks. Optional macro SAMPLE_SCHED_UNDERRUN_CNT_EN adds a saturating underrun_count.
module sample_scheduler #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int CLKS_PER_SAMPLE = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DATA_WIDTH-1:0]         in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         sample,
  output logic                          new_sample,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underrun
`ifdef SAMPLE_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_SAMPLE);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] HALF_LEVEL = LW'(FIFO_DEPTH / 2);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [TW-1:0] TICK_ONE   = TW'(1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLKS_PER_SAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t                  state;
  logic [TW-1:0]           tick;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic                    wr_en;
  logic                    at_tc;
  logic                    pop;
  logic                    miss;

  // Terminal count is only honoured while still enabled, so an enable drop suppresses the pop.
  assign in_ready = (level != FULL_LEVEL);
  assign wr_en    = in_valid & in_ready;
  assign at_tc    = (state == RUN) & enable & (tick == TICK_LAST);
  assign pop      = at_tc & (level != '0);
  assign miss     = at_tc & (level == '0);

  // Sample storage; a write during reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= in_sample;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Scheduling FSM with registered sample, strobe and underrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick       <= '0;
      sample     <= '0;
      new_sample <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      new_sample <= 1'b0;
      underrun   <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        tick  <= '0;
      end else begin
        case (state)
          IDLE: begin
            tick  <= '0;
            state <= PRIME;
          end
          PRIME: begin
            tick <= '0;
            if (level >= HALF_LEVEL) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (at_tc) begin
              tick <= '0;
              if (pop) begin
                sample     <= mem[rd_ptr];
                new_sample <= 1'b1;
              end else begin
                underrun <= 1'b1;
                state    <= PRIME;
              end
            end else begin
              tick <= tick + TICK_ONE;
            end
          end
          default: begin
            state <= IDLE;
            tick  <= '0;
          end
        endcase
      end
    end
  end

`ifdef SAMPLE_SCHED_UNDERRUN_CNT_EN
  // Saturating count of underrun events.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_count <= 16'h0000;
    end else if (miss && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'h0001;
    end else begin
      underrun_count <= underrun_count;
    end
  end
`endif

endmodule
